// File: rtl/main_memory_pkg.sv
// Shared types and sizing helpers for the block-granular backing memory.
// Defaults mirror the cache-side geometry (4 x 32-bit words per block).
package main_memory_pkg;

    localparam int DEF_WORD_SIZE       = 32;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_BLOCK_SIZE      = DEF_WORD_SIZE * DEF_WORDS_PER_BLOCK;
    localparam int DEF_ADDR_WIDTH      = 30;
    localparam int DEF_MEM_DEPTH       = 1024;
    localparam int DEF_RD_LATENCY      = 4;
    localparam int DEF_WR_LATENCY      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY,
        RD_RESP
    } mem_state_t;

    // Counter must hold the larger latency minus one, plus headroom.
    function automatic int lat_width(input int rd_lat, input int wr_lat);
        return $clog2(((rd_lat > wr_lat) ? rd_lat : wr_lat) + 1);
    endfunction

    localparam int MEM_IDX_W = $clog2(DEF_MEM_DEPTH);
    localparam int LAT_W     = lat_width(DEF_RD_LATENCY, DEF_WR_LATENCY);

    typedef logic [DEF_BLOCK_SIZE-1:0] block_t;

endpackage

// File: rtl/main_memory_block_array.sv
// Single-port block storage with registered read data.
// Storage is never reset; only the read register clears on reset.
module mem_block_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Commit a block on write enable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Capture a block on read enable and hold it until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_memory_block.sv
// Memory-side stage: accepts refill reads and dirty write-backs,
// services each after a fixed latency, one request at a time.
module main_memory_block
    import main_memory_pkg::*;
#(
    parameter int WORD_SIZE       = DEF_WORD_SIZE,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH       = DEF_MEM_DEPTH,
    parameter int RD_LATENCY      = DEF_RD_LATENCY,
    parameter int WR_LATENCY      = DEF_WR_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_mem,
    input  logic                  write_en_mem,
    input  logic                  valid_cache,
    input  logic                  ready_cache,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0] dirty_block_in,
    output logic [BLOCK_SIZE-1:0] data_out_mem,
    output logic                  valid_mem,
    output logic                  ready_mem,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = lat_width(RD_LATENCY, WR_LATENCY);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_state_t            state;
    mem_state_t            state_next;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      addr_q;
    logic [BLOCK_SIZE-1:0] wdata_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  cnt_zero;
    logic                  arr_we;
    logic                  arr_re;
    logic                  unused_addr_hi;

    // Upper address bits alias onto the same blocks.
    assign unused_addr_hi = ^mem_addr[ADDR_WIDTH-1:IDX_W];

    // A write-back beats a concurrent refill; the refill stays pending.
    assign wr_acc   = (state == IDLE) & write_en_mem & valid_cache;
    assign rd_acc   = (state == IDLE) & ~wr_acc & read_en_mem;
    assign cnt_zero = (cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (wr_acc) begin
                    state_next = WR_BUSY;
                end else if (rd_acc) begin
                    state_next = RD_BUSY;
                end
            end
            WR_BUSY: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                end
            end
            RD_BUSY: begin
                if (cnt_zero) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (ready_cache) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs and array strobes decoded from state.
    always_comb begin
        ready_mem = (state == IDLE) & rst;
        valid_mem = (state == RD_RESP);
        busy      = (state != IDLE);
        arr_we    = (state == WR_BUSY) & cnt_zero;
        arr_re    = (state == RD_BUSY) & cnt_zero;
    end

    // Latch the request and run the latency counter down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (wr_acc) begin
            cnt     <= WR_LOAD;
            addr_q  <= mem_addr[IDX_W-1:0];
            wdata_q <= dirty_block_in;
        end else if (rd_acc) begin
            cnt     <= RD_LOAD;
            addr_q  <= mem_addr[IDX_W-1:0];
        end else if (busy && !cnt_zero) begin
            cnt     <= cnt - CNT_ONE;
        end
    end

    mem_block_array #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (BLOCK_SIZE),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (data_out_mem)
    );

endmodule

// File: tb/tb_main_memory_block.sv
// Bench for main_memory_block: directed scenarios plus a random
// read/write mix checked against a plain array model of memory.
module tb_main_memory_block;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_en_mem;
    logic         write_en_mem;
    logic         valid_cache;
    logic         ready_cache;
    logic [29:0]  mem_addr;
    logic [127:0] dirty_block_in;
    logic [127:0] data_out_mem;
    logic         valid_mem;
    logic         ready_mem;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] model [int];

    always #5 clk = ~clk;

    main_memory_block dut (
        .clk            (clk),
        .rst            (rst),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem),
        .valid_cache    (valid_cache),
        .ready_cache    (ready_cache),
        .mem_addr       (mem_addr),
        .dirty_block_in (dirty_block_in),
        .data_out_mem   (data_out_mem),
        .valid_mem      (valid_mem),
        .ready_mem      (ready_mem),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a write-back, wait for accept, count busy cycles.
    task automatic wr(input logic [29:0] a, input logic [127:0] d,
                      output int busy_cyc);
        int guard;
        write_en_mem   = 1'b1;
        valid_cache    = 1'b1;
        mem_addr       = a;
        dirty_block_in = d;
        guard = 0;
        while (!ready_mem && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (!ready_mem) begin
            n_fail++;
            $display("FAIL wr_accept_timeout: ready_mem=%b required 1", ready_mem);
        end
        tick();
        write_en_mem = 1'b0;
        valid_cache  = 1'b0;
        busy_cyc = 0;
        while (!ready_mem && busy_cyc < 50) begin
            tick();
            busy_cyc++;
        end
        model[int'(a[9:0])] = d;
    endtask

    // Present a refill read, stall ready_cache for 'stall' valid cycles.
    task automatic rd(input logic [29:0] a, input int stall,
                      output logic [127:0] d, output int lat,
                      output bit stable, output bit pulse_ok);
        int guard;
        read_en_mem = 1'b1;
        mem_addr    = a;
        ready_cache = (stall == 0);
        guard = 0;
        while (!ready_mem && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (!ready_mem) begin
            n_fail++;
            $display("FAIL rd_accept_timeout: ready_mem=%b required 1", ready_mem);
        end
        tick();
        read_en_mem = 1'b0;
        lat = 1;
        while (!valid_mem && lat < 50) begin
            tick();
            lat++;
        end
        d = data_out_mem;
        stable = 1'b1;
        for (int i = 1; i <= stall; i++) begin
            tick();
            if (!valid_mem || data_out_mem !== d) stable = 1'b0;
        end
        ready_cache = 1'b1;
        tick();
        pulse_ok = !valid_mem && ready_mem && (data_out_mem === d);
        ready_cache = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        read_en_mem = 1'b0;
        write_en_mem = 1'b0;
        valid_cache = 1'b0;
        ready_cache = 1'b0;
        mem_addr = '0;
        dirty_block_in = '0;
        tick();
        tick();
        n_checks++;
        if (valid_mem !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b required 0", valid_mem);
        end
        n_checks++;
        if (ready_mem !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 0", ready_mem);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
        n_checks++;
        if (data_out_mem !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", data_out_mem);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ready_mem !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", ready_mem);
        end
        tick();
    endtask

    task automatic test_basic_read();
        logic [127:0] d;
        logic [127:0] pat;
        int lat;
        int bc;
        bit st;
        bit po;
        pat = {16{8'hA5}};
        wr(30'h005, pat, bc);
        rd(30'h005, 0, d, lat, st, po);
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required 5", lat);
        end
        n_checks++;
        if (d !== pat) begin
            n_fail++;
            $display("FAIL basic_data: got %h required %h", d, pat);
        end
        n_checks++;
        if (!po) begin
            n_fail++;
            $display("FAIL basic_pulse: valid=%b ready=%b required 0/1", valid_mem, ready_mem);
        end
    endtask

    task automatic test_write_then_read();
        logic [127:0] d;
        logic [127:0] pat;
        int lat;
        int bc;
        bit st;
        bit po;
        pat = 128'h1111_2222_3333_4444;
        wr(30'h010, pat, bc);
        n_checks++;
        if (bc != 4) begin
            n_fail++;
            $display("FAIL wr_busy_cycles: got %0d required 4", bc);
        end
        rd(30'h010, 0, d, lat, st, po);
        n_checks++;
        if (d !== pat) begin
            n_fail++;
            $display("FAIL raw_data: got %h required %h", d, pat);
        end
    endtask

    task automatic test_simultaneous();
        logic [127:0] pat;
        int n;
        pat = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;
        write_en_mem   = 1'b1;
        valid_cache    = 1'b1;
        read_en_mem    = 1'b1;
        mem_addr       = 30'h033;
        dirty_block_in = pat;
        ready_cache    = 1'b1;
        n_checks++;
        if (ready_mem !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_ready_idle: got %b required 1", ready_mem);
        end
        tick();
        write_en_mem = 1'b0;
        valid_cache  = 1'b0;
        n = 0;
        while (!ready_mem && n < 50) begin
            if (valid_mem) n = 100;
            tick();
            n++;
        end
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL sim_write_first: busy cycles %0d required 4", n);
        end
        tick();
        read_en_mem = 1'b0;
        n = 1;
        while (!valid_mem && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 5 || data_out_mem !== pat) begin
            n_fail++;
            $display("FAIL sim_read_after: lat %0d data %h required 5 %h", n, data_out_mem, pat);
        end
        tick();
        ready_cache = 1'b0;
        model[int'(10'h033)] = pat;
    endtask

    task automatic test_stall();
        logic [127:0] d;
        int lat;
        bit st;
        bit po;
        rd(30'h010, 3, d, lat, st, po);
        n_checks++;
        if (!st) begin
            n_fail++;
            $display("FAIL stall_stable: got unstable required stable");
        end
        n_checks++;
        if (d !== model[int'(10'h010)]) begin
            n_fail++;
            $display("FAIL stall_data: got %h required %h", d, model[int'(10'h010)]);
        end
        n_checks++;
        if (!po) begin
            n_fail++;
            $display("FAIL stall_complete: valid=%b ready=%b required 0/1", valid_mem, ready_mem);
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] d;
        int lat;
        int bc;
        bit st;
        bit po;
        wr(30'h020, 128'h0, bc);
        write_en_mem   = 1'b1;
        valid_cache    = 1'b1;
        mem_addr       = 30'h020;
        dirty_block_in = {4{32'hFEED_FACE}};
        tick();
        write_en_mem = 1'b0;
        valid_cache  = 1'b0;
        tick();
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ready_mem !== 1'b0 || valid_mem !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b ready=%b valid=%b required 0/0/0",
                     busy, ready_mem, valid_mem);
        end
        n_checks++;
        if (data_out_mem !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_data: got %h required 0", data_out_mem);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        rd(30'h020, 0, d, lat, st, po);
        n_checks++;
        if (d !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_discard: got %h required 0", d);
        end
    endtask

    task automatic test_wrap();
        logic [127:0] d;
        logic [127:0] pat;
        int lat;
        int bc;
        bit st;
        bit po;
        pat = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
        wr(30'h000400, pat, bc);
        rd(30'h000000, 0, d, lat, st, po);
        n_checks++;
        if (d !== pat) begin
            n_fail++;
            $display("FAIL wrap_data: got %h required %h", d, pat);
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [127:0] pat;
        logic [29:0]  a;
        logic [9:0]   pool [8];
        int lat;
        int bc;
        int k;
        bit st;
        bit po;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom);
            a = 30'($urandom);
            a[9:0] = pool[i];
            pat = {$urandom, $urandom, $urandom, $urandom};
            wr(a, pat, bc);
        end
        for (int i = 0; i < 30; i++) begin
            k = int'($urandom_range(0, 7));
            a = 30'($urandom);
            a[9:0] = pool[k];
            if ($urandom_range(0, 1) == 0) begin
                pat = {$urandom, $urandom, $urandom, $urandom};
                wr(a, pat, bc);
                n_checks++;
                if (bc != 4) begin
                    n_fail++;
                    $display("FAIL rand_wr_busy[%0d]: got %0d required 4", i, bc);
                end
            end else begin
                rd(a, int'($urandom_range(0, 3)), d, lat, st, po);
                n_checks++;
                if (d !== model[int'(a[9:0])] || lat != 5 || !st || !po) begin
                    n_fail++;
                    $display("FAIL rand_rd[%0d]: got %h lat %0d st %b po %b required %h lat 5",
                             i, d, lat, st, po, model[int'(a[9:0])]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_write_then_read();
        test_simultaneous();
        test_stall();
        test_reset_abort();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_memory_block.md
Name: main_memory_block

Overview:
- Block-granular backing memory that sits directly downstream of the 2-way cache controller/cache memory pair.
- Serves refill reads (read_en_mem) and dirty write-backs (write_en_mem with valid_cache) over the existing ready/valid signals.
- Returns a full BLOCK_SIZE line on data_out_mem, after a programmable latency.
- Serves as both the synthesizable memory-side stage and the bench's memory model.

Parameters:
- WORD_SIZE, 32, bits per word
- WORDS_PER_BLOCK, 4, words per cache block
- BLOCK_SIZE, WORD_SIZE*WORDS_PER_BLOCK, bits per transferred block
- ADDR_WIDTH, 30, block address width ({tag,index} = 25+5)
- MEM_DEPTH, 1024, number of stored blocks (power of two)
- RD_LATENCY, 4, cycles from read accept to valid_mem (>=1)
- WR_LATENCY, 4, cycles from write accept to commit (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- read_en_mem  in  1  refill request from controller; level, held until handshake
- write_en_mem  in  1  write-back request from controller
- valid_cache  in  1  cache presents a dirty block on dirty_block_in
- ready_cache  in  1  cache can accept refill data
- mem_addr  in  ADDR_WIDTH  block address, sampled at request accept
- dirty_block_in  in  BLOCK_SIZE  write-back data, sampled at write accept
- data_out_mem  out  BLOCK_SIZE  refill data, stable while valid_mem=1
- valid_mem  out  1  refill data valid
- ready_mem  out  1  memory can accept a new request
- busy  out  1  any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, valid_mem=0, data_out_mem=0, busy=0, latency counter=0, latched addr/data=0. ready_mem=0 while in reset and 1 in the first IDLE cycle after release. Storage array is not reset. Reset mid-operation aborts: an uncommitted write is discarded and a pending valid_mem drops immediately.
- Array index is mem_addr[$clog2(MEM_DEPTH)-1:0]. Upper bits are ignored, so aliasing wraps modulo MEM_DEPTH.
- FSM states:
  - IDLE: ready_mem=1.
    - Write accept: write_en_mem & valid_cache. Latch addr and dirty_block_in, counter=WR_LATENCY-1, go to WR_BUSY.
    - Otherwise read accept: read_en_mem. Latch addr, counter=RD_LATENCY-1, go to RD_BUSY.
    - Simultaneous read and write requests: write wins. The read stays pending because the controller holds read_en_mem, and it is accepted after the write commits.
  - WR_BUSY: ready_mem=0. Counter decrements each cycle. When counter=0, write the latched block to the array at the latched addr, then go to IDLE. With write accepted in cycle T, the commit edge ends cycle T+WR_LATENCY and ready_mem=1 in cycle T+WR_LATENCY+1.
  - RD_BUSY: ready_mem=0. Counter decrements. When counter=0, register array[latched addr] into data_out_mem and go to RD_RESP. With read accepted in cycle T, valid_mem=1 from cycle T+RD_LATENCY+1.
  - RD_RESP: valid_mem=1, ready_mem=0, data_out_mem held. On valid_mem & ready_cache, the transfer completes that cycle; next state IDLE, valid_mem=0 next cycle, data_out_mem retains its value.
- Ordering: a read after a write to the same block returns the new data, because the write commits before any read is accepted.
- Requests outside IDLE are ignored, not queued. Requesters hold request levels until accepted.
- Counter width is $clog2(max(RD_LATENCY,WR_LATENCY)+1). No wider arithmetic is used.

Decomposition:
- Package main_memory_pkg holds:
  - the mem_state_t enum (IDLE, WR_BUSY, RD_BUSY, RD_RESP);
  - the localparams MEM_IDX_W=$clog2(MEM_DEPTH) and LAT_W;
  - a block_t typedef of width BLOCK_SIZE.
- One sub-module, mem_block_array, holds the storage array: MEM_DEPTH x BLOCK_SIZE, synchronous single-port, with write enable, address, write data and registered read data. The FSM, counter and handshake stay in main_memory_block.

Test Plan:
1. Reset, then a read request on an array preloaded at addr 0x005 with 128'hA5A5...A5 and ready_cache=1. Expect valid_mem high exactly 5 cycles after accept (RD_LATENCY=4), data_out_mem=A5A5...A5, a one-cycle pulse, and ready_mem back to 1 the next cycle.
2. Write-back to addr 0x010 with data 128'h1111_2222_3333_4444 (write_en_mem=valid_cache=1), immediately followed by a held read of 0x010. Expect ready_mem low for 4 cycles, then the read is accepted and returns 1111_2222_3333_4444.
3. Simultaneous write_en_mem+valid_cache and read_en_mem in IDLE. Expect the write to be accepted first (WR_BUSY) and the read to be served after commit.
4. ready_cache held 0 for 3 cycles during RD_RESP. Expect valid_mem and data_out_mem to stay stable for all 3 cycles and the transfer to complete in the cycle ready_cache=1.
5. rst=0 in the second cycle of WR_BUSY, addr 0x020, prior content 0. Expect outputs at reset values asynchronously, and a later read of 0x020 returns 0 (write discarded).
6. Write to mem_addr 0x000400, then read 0x000000 (MEM_DEPTH=1024). Expect the written data back (index wrap).
